// File: rtl/uart_axi_burst_packer_if.sv
// uart_axi_burst_packer_if
//   Bundles the byte-stream input, the AXI write address/data/response
//   channels and the status outputs of the UART -> AXI burst packer.
//   master : packer side (consumes bytes, drives AXI write requests)
//   slave  : environment side (byte source + DDR controller + status reader)
interface uart_axi_burst_packer_if;
    // byte stream from the UART RX FIFO
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    // AXI write address channel
    logic [7:0]   aid;
    logic [31:0]  aaddr;
    logic [7:0]   alen;
    logic [2:0]   asize;
    logic [1:0]   aburst;
    logic [1:0]   alock;
    logic         atype;
    logic         avalid;
    logic         aready;
    // AXI write data channel
    logic [7:0]   wid;
    logic [255:0] wdata;
    logic [31:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    // AXI write response channel
    logic [7:0]   bid;
    logic         bvalid;
    logic         bready;
    // status
    logic         busy;
    logic [15:0]  burst_cnt;

    modport master (
        input  in_data, in_valid, flush, aready, wready, bid, bvalid,
        output in_ready, aid, aaddr, alen, asize, aburst, alock, atype, avalid,
               wid, wdata, wstrb, wlast, wvalid, bready, busy, burst_cnt
    );

    modport slave (
        output in_data, in_valid, flush, aready, wready, bid, bvalid,
        input  in_ready, aid, aaddr, alen, asize, aburst, alock, atype, avalid,
               wid, wdata, wstrb, wlast, wvalid, bready, busy, burst_cnt
    );
endinterface

// File: rtl/uart_axi_burst_packer.sv
// uart_axi_burst_packer
//   Packs a UART byte stream into 256-bit beats and writes them to DDR as
//   fixed-length INCR bursts at sequential, wrapping addresses. A flush
//   pushes out a partial beat and zero-strobe-pads the rest of the burst.
// Ports
//   axi_clk : clock for all logic
//   rst     : asynchronous active-high reset
//   bus     : byte input, AXI write AW/W/B channels, busy/burst_cnt status
module uart_axi_burst_packer #(
    parameter int unsigned ALEN        = 23,
    parameter int unsigned ASIZE       = 5,
    parameter logic [31:0] START_ADDR  = 32'h0000_0000,
    parameter logic [31:0] STOP_ADDR   = 32'h0010_0000,
    parameter logic [31:0] ADDR_OFFSET = 32'((ALEN + 1) * 32)
) (
    input  logic                    axi_clk,
    input  logic                    rst,
    uart_axi_burst_packer_if.master bus
);
    localparam logic [7:0] ALEN_B  = 8'(ALEN);
    localparam logic [2:0] ASIZE_B = 3'(ASIZE);

    typedef enum logic [1:0] {IDLE, WRITE_ADDR, WRITE_DATA, WAIT_RESP} state_t;

    state_t        state;
    logic [255:0]  pack_data, buf_data;
    logic [31:0]   pack_strb, buf_strb;
    logic [5:0]    pack_cnt;           // bytes held in the packer, 0..32
    logic          buf_full;
    logic          flush_pend;
    logic [7:0]    beat_cnt;
    logic          avalid_r, bready_r;
    logic [31:0]   aaddr_r;
    logic [15:0]   burst_cnt_r;

    logic          padding, wvalid_c, w_acc, buf_free, xfer, b_acc, last_beat;
    logic [32:0]   addr_sum;
    logic          unused_bid;

    // Padding: a flush is pending but no real data is left to send, so the
    // remaining beats of the burst go out empty. New bytes are held off so
    // they cannot sneak into a burst that is being closed.
    assign padding   = (state == WRITE_DATA) && flush_pend && (pack_cnt == 6'd0) && !buf_full;
    assign wvalid_c  = (state == WRITE_DATA) && (buf_full || padding);
    assign w_acc     = wvalid_c && bus.wready;
    assign buf_free  = !buf_full || w_acc;
    assign xfer      = ((pack_cnt == 6'd32) || (flush_pend && (pack_cnt != 6'd0))) && buf_free;
    assign b_acc     = bus.in_valid && bus.in_ready;
    assign last_beat = (beat_cnt == ALEN_B);
    assign addr_sum  = {1'b0, aaddr_r} + {1'b0, ADDR_OFFSET};

    assign bus.in_ready  = !pack_cnt[5] && !padding;
    assign bus.aid       = 8'h00;
    assign bus.aaddr     = aaddr_r;
    assign bus.alen      = avalid_r ? ALEN_B : 8'h00;
    assign bus.asize     = avalid_r ? ASIZE_B : 3'd0;
    assign bus.aburst    = avalid_r ? 2'b01 : 2'b00;
    assign bus.alock     = 2'b00;
    assign bus.atype     = avalid_r;
    assign bus.avalid    = avalid_r;
    assign bus.wid       = 8'h00;
    assign bus.wdata     = buf_full ? buf_data : '0;
    assign bus.wstrb     = buf_full ? buf_strb : '0;
    assign bus.wlast     = wvalid_c && last_beat;
    assign bus.wvalid    = wvalid_c;
    assign bus.bready    = bready_r;
    assign bus.busy      = (state != IDLE) || (pack_cnt != 6'd0) || buf_full;
    assign bus.burst_cnt = burst_cnt_r;
    assign unused_bid    = ^bus.bid;

    // Packer and single-beat buffer. Packing runs in every state; only the
    // hand-off into the buffer waits for the buffer to drain.
    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            pack_data <= '0;
            pack_strb <= '0;
            pack_cnt  <= '0;
            buf_data  <= '0;
            buf_strb  <= '0;
            buf_full  <= 1'b0;
        end else begin
            if (xfer) begin
                buf_data <= pack_data;
                buf_strb <= pack_strb;
                buf_full <= 1'b1;
            end else if (w_acc) begin
                buf_full <= 1'b0;
            end

            if (xfer) begin
                // a byte arriving on the hand-off cycle starts the fresh beat
                pack_data <= b_acc ? {248'b0, bus.in_data} : '0;
                pack_strb <= b_acc ? 32'h1 : 32'h0;
                pack_cnt  <= b_acc ? 6'd1 : 6'd0;
            end else if (b_acc) begin
                pack_data[{pack_cnt[4:0], 3'b000} +: 8] <= bus.in_data;
                pack_strb[pack_cnt[4:0]]               <= 1'b1;
                pack_cnt                               <= pack_cnt + 6'd1;
            end
        end
    end

    // Burst sequencer with registered AXI control outputs.
    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            avalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            beat_cnt    <= '0;
            aaddr_r     <= START_ADDR;
            burst_cnt_r <= '0;
            flush_pend  <= 1'b0;
        end else begin
            if (bus.flush && ((pack_cnt != 6'd0) || (state != IDLE)))
                flush_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if ((pack_cnt != 6'd0) || buf_full) begin
                        state    <= WRITE_ADDR;
                        avalid_r <= 1'b1;
                    end
                end
                WRITE_ADDR: begin
                    if (bus.aready) begin
                        avalid_r <= 1'b0;
                        beat_cnt <= '0;
                        state    <= WRITE_DATA;
                    end
                end
                WRITE_DATA: begin
                    if (w_acc) begin
                        if (last_beat) begin
                            bready_r <= 1'b1;
                            state    <= WAIT_RESP;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (bus.bvalid) begin
                        bready_r    <= 1'b0;
                        aaddr_r     <= (addr_sum >= {1'b0, STOP_ADDR}) ? START_ADDR : addr_sum[31:0];
                        burst_cnt_r <= burst_cnt_r + 16'd1;
                        flush_pend  <= 1'b0;   // the burst this flush closed is done
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_axi_burst_packer.sv
// tb_uart_axi_burst_packer
//   Directed and randomized byte streams against a queue-based model of the
//   expected memory traffic: bytes grouped 32 per beat, bursts of ALEN+1
//   beats, flush closes the partial beat and zero-pads the burst.
module tb_uart_axi_burst_packer;
    localparam int          BPB   = 2;          // beats per burst (ALEN+1)
    localparam logic [31:0] START = 32'h0;
    localparam logic [31:0] STOP  = 32'h80;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  strb;
        logic         last;
    } beat_t;

    logic axi_clk = 1'b0;
    logic rst     = 1'b1;
    uart_axi_burst_packer_if bus();

    uart_axi_burst_packer #(
        .ALEN(1), .ASIZE(5), .START_ADDR(START), .STOP_ADDR(STOP)
    ) dut (
        .axi_clk (axi_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 axi_clk = ~axi_clk;

    int checks = 0;
    int errors = 0;

    // model state
    logic [7:0]  pend[$];
    beat_t       exp_q[$];
    logic [31:0] exp_addr_q[$];
    int          m_beats  = 0;
    int          m_bursts = 0;
    logic [31:0] m_addr   = START;

    // observed traffic
    beat_t       cap_q[$];
    logic [31:0] cap_addr_q[$];

    // ready/response pattern control
    int w_mode = 0;   // 0 always, 1 toggle, 2 random, 3 never
    bit a_rand = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_emit(input logic [255:0] d, input logic [31:0] s);
        beat_t b;
        if (m_beats % BPB == 0) exp_addr_q.push_back(m_addr);
        b.data = d;
        b.strb = s;
        b.last = (m_beats % BPB == BPB - 1);
        exp_q.push_back(b);
        m_beats++;
        if (b.last) begin
            m_bursts++;
            m_addr = m_addr + 32'(BPB * 32);
            if (m_addr >= STOP) m_addr = START;
        end
    endtask

    task automatic model_pack();
        logic [255:0] d;
        logic [31:0]  s;
        d = '0;
        s = '0;
        for (int k = 0; k < pend.size(); k++) begin
            d[8*k +: 8] = pend[k];
            s[k] = 1'b1;
        end
        pend.delete();
        model_emit(d, s);
    endtask

    task automatic model_push(input logic [7:0] b);
        pend.push_back(b);
        if (pend.size() == 32) model_pack();
    endtask

    task automatic model_flush();
        if (pend.size() > 0) model_pack();
        while (m_beats % BPB != 0) model_emit('0, '0);
    endtask

    task automatic model_reset();
        pend.delete();
        exp_q.delete();
        exp_addr_q.delete();
        cap_q.delete();
        cap_addr_q.delete();
        m_beats  = 0;
        m_bursts = 0;
        m_addr   = START;
    endtask

    // Call at posedge+#1; returns at posedge+#1 after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 3000; i++) begin
            @(negedge axi_clk);
            if (bus.in_ready) begin
                ok = 1;
                @(posedge axi_clk); #1;
                break;
            end
            @(posedge axi_clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("byte accept timeout", 256'(ok), 256'd1);
        if (ok) model_push(b);
        repeat (gap) begin @(posedge axi_clk); #1; end
    endtask

    // Wait for the packer to go idle; optionally re-issue flush periodically
    // (a flush is a no-op while one is pending).
    task automatic wait_idle(input bit fl);
        bit done;
        done = 0;
        for (int i = 0; i < 6000; i++) begin
            bus.flush = fl && (i % 50 == 0);
            @(negedge axi_clk);
            if (!bus.busy) begin
                done = 1;
                break;
            end
            @(posedge axi_clk); #1;
        end
        bus.flush = 1'b0;
        chk("idle timeout", 256'(done), 256'd1);
        @(posedge axi_clk); #1;
    endtask

    task automatic compare_all(input string tag);
        beat_t e, c;
        chk({tag, " beat count"}, 256'(cap_q.size()), 256'(exp_q.size()));
        while (exp_q.size() > 0 && cap_q.size() > 0) begin
            e = exp_q.pop_front();
            c = cap_q.pop_front();
            chk({tag, " wdata"}, c.data, e.data);
            chk({tag, " wstrb"}, 256'(c.strb), 256'(e.strb));
            chk({tag, " wlast"}, 256'(c.last), 256'(e.last));
        end
        chk({tag, " burst count"}, 256'(cap_addr_q.size()), 256'(exp_addr_q.size()));
        while (exp_addr_q.size() > 0 && cap_addr_q.size() > 0)
            chk({tag, " aaddr"}, 256'(cap_addr_q.pop_front()), 256'(exp_addr_q.pop_front()));
        chk({tag, " burst_cnt"}, 256'(bus.burst_cnt), 256'(16'(m_bursts)));
        exp_q.delete();
        cap_q.delete();
        exp_addr_q.delete();
        cap_addr_q.delete();
    endtask

    // ready/response drivers
    always @(posedge axi_clk) begin
        #1;
        case (w_mode)
            0:       bus.wready = 1'b1;
            1:       bus.wready = ~bus.wready;
            2:       bus.wready = 1'($urandom_range(0, 1));
            default: bus.wready = 1'b0;
        endcase
        bus.aready = a_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.bvalid = a_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // monitor: handshakes seen at negedge complete on the next posedge
    bit           prev_stall = 0;
    logic [255:0] prev_data;
    logic [31:0]  prev_strb;
    logic         prev_last;
    always @(negedge axi_clk) begin
        beat_t b;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall wvalid", 256'(bus.wvalid), 256'd1);
                chk("stall wdata", bus.wdata, prev_data);
                chk("stall wstrb", 256'(bus.wstrb), 256'(prev_strb));
                chk("stall wlast", 256'(bus.wlast), 256'(prev_last));
            end
            prev_stall = bus.wvalid && !bus.wready;
            prev_data  = bus.wdata;
            prev_strb  = bus.wstrb;
            prev_last  = bus.wlast;
            if (bus.wvalid && bus.wready) begin
                b.data = bus.wdata;
                b.strb = bus.wstrb;
                b.last = bus.wlast;
                cap_q.push_back(b);
            end
            if (bus.avalid && bus.aready) begin
                cap_addr_q.push_back(bus.aaddr);
                chk("alen", 256'(bus.alen), 256'd1);
                chk("asize", 256'(bus.asize), 256'd5);
                chk("aburst", 256'(bus.aburst), 256'd1);
                chk("atype", 256'(bus.atype), 256'd1);
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.flush    = 1'b0;
        bus.bid      = 8'h00;
        bus.wready   = 1'b0;
        bus.aready   = 1'b1;
        bus.bvalid   = 1'b1;
        repeat (3) @(posedge axi_clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge axi_clk);
        chk("reset avalid", 256'(bus.avalid), 256'd0);
        chk("reset wvalid", 256'(bus.wvalid), 256'd0);
        chk("reset bready", 256'(bus.bready), 256'd0);
        chk("reset in_ready", 256'(bus.in_ready), 256'd1);
        chk("reset aaddr", 256'(bus.aaddr), 256'(START));
        chk("reset burst_cnt", 256'(bus.burst_cnt), 256'd0);
        chk("reset busy", 256'(bus.busy), 256'd0);
        chk("reset alen", 256'(bus.alen), 256'd0);
        chk("reset wdata", bus.wdata, 256'd0);
        @(posedge axi_clk); #1;

        // two full beats, one burst at START
        for (int i = 0; i < 64; i++) send_byte(8'(i), 0);
        wait_idle(0);
        compare_all("s64");

        // 40 bytes + flush: full beat then 8-byte partial
        for (int i = 0; i < 40; i++) send_byte(8'(i + 8'h40), 0);
        model_flush();
        wait_idle(1);
        compare_all("s40flush");

        // 10 bytes + flush: partial beat then a padding beat, address wraps
        for (int i = 0; i < 10; i++) send_byte(8'(i + 8'hA0), 0);
        model_flush();
        wait_idle(1);
        compare_all("s10flush");

        // wready toggling, 128 bytes, two bursts
        w_mode = 1;
        for (int i = 0; i < 128; i++) send_byte(8'($urandom_range(0, 255)), 0);
        wait_idle(0);
        compare_all("toggle128");

        // randomized streams with random handshake behaviour
        for (int r = 0; r < 6; r++) begin
            int n;
            bit fl;
            n = $urandom_range(1, 150);
            w_mode = $urandom_range(0, 2);
            a_rand = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++)
                send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 2));
            fl = (n % 64 != 0) || ($urandom_range(0, 1) == 1);
            if (fl) model_flush();
            wait_idle(fl);
            compare_all("random");
        end

        // reset in the middle of a burst with the data channel stalled
        w_mode = 3;
        a_rand = 0;
        for (int i = 0; i < 40; i++) send_byte(8'(i), 0);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 500; i++) begin
                @(negedge axi_clk);
                if (bus.wvalid) begin
                    seen = 1;
                    break;
                end
            end
            chk("mid-burst wvalid", 256'(seen), 256'd1);
        end
        @(posedge axi_clk); #1 rst = 1'b1;
        @(negedge axi_clk);
        chk("rst avalid", 256'(bus.avalid), 256'd0);
        chk("rst wvalid", 256'(bus.wvalid), 256'd0);
        chk("rst bready", 256'(bus.bready), 256'd0);
        chk("rst aaddr", 256'(bus.aaddr), 256'(START));
        chk("rst burst_cnt", 256'(bus.burst_cnt), 256'd0);
        chk("rst in_ready", 256'(bus.in_ready), 256'd1);
        @(posedge axi_clk); #1 rst = 1'b0;
        model_reset();
        w_mode = 0;
        repeat (3) @(negedge axi_clk);
        chk("post-rst busy", 256'(bus.busy), 256'd0);
        chk("post-rst avalid", 256'(bus.avalid), 256'd0);
        @(posedge axi_clk); #1;

        // normal operation resumes from START
        for (int i = 0; i < 64; i++) send_byte(8'(8'hFF - i), 0);
        wait_idle(0);
        compare_all("after-rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
